// File: rtl/hb_duty_rx.sv
`default_nettype none
// ============================================================================
// Module   : hb_duty_rx
// Purpose  : SPI duty-frame receiver with double-buffered commit on clk_int
//            and starvation fault after consecutive missed windows.
// Revision : 1.0
// ============================================================================
module hb_duty_rx #(
    parameter int DMAX       = 1000,
    parameter int MISS_LIMIT = 4,
    parameter int TIMEOUT    = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_int,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic [9:0] d_inv,
    output logic       rx_ok,
    output logic       rx_err,
    output logic       fault
);

    localparam int         c_TCNT_W = $clog2(TIMEOUT + 1);
    localparam int         c_MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [9:0] c_DMAX   = 10'(DMAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHIFT = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                  r_cs_s1, r_cs_s2, r_cs_d;
    logic                  r_mosi_s1, r_mosi_s2;
    logic                  r_int_q, r_int_rise;
    logic [15:0]           r_sr;
    logic [4:0]            r_bcnt;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic [c_MISS_W-1:0]   r_miss;
    logic [9:0]            r_shadow;
    logic                  r_shadow_v;

    logic       w_sclk_rise, w_cs_fall, w_cs_rise, w_good, w_tmo;
    logic [9:0] w_duty_clamped;

    assign w_sclk_rise    = r_sclk_s2 & ~r_sclk_d;
    assign w_cs_fall      = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise      = r_cs_s2 & ~r_cs_d;
    assign w_good         = (r_bcnt == 5'd16) && (r_sr[15:12] == 4'b1010);
    assign w_tmo          = (r_tcnt == c_TCNT_W'(TIMEOUT));
    assign w_duty_clamped = (r_sr[9:0] > c_DMAX) ? c_DMAX : r_sr[9:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sclk_s1  <= 1'b1;
            r_sclk_s2  <= 1'b1;
            r_sclk_d   <= 1'b1;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_d     <= 1'b1;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
            r_int_q    <= 1'b0;
            r_int_rise <= 1'b0;
            r_sr       <= '0;
            r_bcnt     <= '0;
            r_tcnt     <= '0;
            r_miss     <= '0;
            r_shadow   <= '0;
            r_shadow_v <= 1'b0;
            d_inv      <= '0;
            rx_ok      <= 1'b0;
            rx_err     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            r_sclk_s1  <= sclk;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_d   <= r_sclk_s2;
            r_cs_s1    <= cs_n;
            r_cs_s2    <= r_cs_s1;
            r_cs_d     <= r_cs_s2;
            r_mosi_s1  <= mosi;
            r_mosi_s2  <= r_mosi_s1;
            r_int_q    <= clk_int;
            // Registered rise pulse gives the two-cycle commit latency
            r_int_rise <= clk_int & ~r_int_q;
            rx_ok      <= 1'b0;
            rx_err     <= 1'b0;

            if (r_int_rise) begin
                if (r_shadow_v) begin
                    d_inv      <= r_shadow;
                    r_shadow_v <= 1'b0;
                    r_miss     <= '0;
                    fault      <= 1'b0;
                end else if (r_miss >= c_MISS_W'(MISS_LIMIT - 1)) begin
                    r_miss <= c_MISS_W'(MISS_LIMIT);
                    fault  <= 1'b1;
                    d_inv  <= '0;
                end else begin
                    r_miss <= r_miss + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    if (r_int_rise) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (r_int_rise) begin
                        r_tcnt <= '0;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                        rx_err  <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (w_cs_fall) begin
                            r_state <= S_SHIFT;
                            r_bcnt  <= '0;
                            r_sr    <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_sr <= {r_sr[14:0], r_mosi_s2};
                        // Saturate past 16 so an over-long frame fails CHECK
                        if (r_bcnt < 5'd17) r_bcnt <= r_bcnt + 1'b1;
                    end
                    if (r_int_rise) begin
                        r_tcnt <= '0;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                        rx_err  <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (w_cs_rise) r_state <= S_CHECK;
                    end
                end
                default: begin
                    // Set after the commit above so a same-cycle commit uses the old shadow
                    if (w_good) begin
                        r_shadow   <= w_duty_clamped;
                        r_shadow_v <= 1'b1;
                        rx_ok      <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                    r_tcnt  <= '0;
                    r_state <= r_int_rise ? S_ARMED : S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hb_duty_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hb_duty_rx
// Purpose  : Directed self-checking bench for hb_duty_rx.
// Revision : 1.0
// ============================================================================
module tb_hb_duty_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_int = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [9:0] d_inv;
    logic       rx_ok, rx_err, fault;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int int_cyc = 0;

    hb_duty_rx #(.DMAX(1000), .MISS_LIMIT(4), .TIMEOUT(20000)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_int (clk_int),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .d_inv   (d_inv),
        .rx_ok   (rx_ok),
        .rx_err  (rx_err),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_ok) ok_cnt = ok_cnt + 1;
        if (rx_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_clk(5);
        sclk = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] d, input int nbits);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) send_bit(d[15-i]);
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic pulse_int();
        clk_int = 1'b1;
        int_cyc = cyc;
        wait_clk(10);
        clk_int = 1'b0;
        wait_clk(10);
    endtask

    initial begin
        logic [15:0] w_f;
        wait_clk(4);
        chk("rst_d_inv", d_inv, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rx_ok", rx_ok, 0);
        chk("rst_rx_err", rx_err, 0);
        rst_n = 1'b1;
        wait_clk(4);

        // Good frame, then exact commit latency
        pulse_int();
        ok_cnt = 0;
        send_frame(16'hA1F4, 16);
        chk("good_rx_ok", ok_cnt, 1);
        chk("good_pending", d_inv, 0);
        clk_int = 1'b1;
        @(negedge clk);
        chk("commit_lat1", d_inv, 0);
        @(negedge clk);
        chk("commit_lat2", d_inv, 500);
        wait_clk(10);
        clk_int = 1'b0;
        wait_clk(10);

        // Clamp
        send_frame(16'hA3FF, 16);
        pulse_int();
        chk("clamp", d_inv, 1000);

        // Bad header
        err_cnt = 0;
        send_frame(16'h51F4, 16);
        chk("badhdr_err", err_cnt, 1);
        pulse_int();
        chk("badhdr_hold", d_inv, 1000);

        // Short frame
        err_cnt = 0;
        ok_cnt = 0;
        send_frame(16'hA1F4, 15);
        chk("short_err", err_cnt, 1);
        chk("short_no_ok", ok_cnt, 0);
        pulse_int();
        chk("short_hold", d_inv, 1000);

        // Restore 500 and clear the miss count
        send_frame(16'hA1F4, 16);
        pulse_int();
        chk("restore", d_inv, 500);

        // Timeout: armed with no frame
        err_cnt = 0;
        for (int i = 0; i < 21000 && err_cnt == 0; i++) @(negedge clk);
        chk("tmo_err", err_cnt, 1);
        chk("tmo_lat", int'((err_cyc - int_cyc) >= 19995 && (err_cyc - int_cyc) <= 20010), 1);

        // Frame in IDLE is ignored
        ok_cnt = 0;
        err_cnt = 0;
        send_frame(16'hA064, 16);
        chk("idle_no_ok", ok_cnt, 0);
        chk("idle_no_err", err_cnt, 0);

        // Starvation: four rises with no frame
        pulse_int();
        pulse_int();
        pulse_int();
        chk("starve3_fault", fault, 0);
        chk("starve3_d", d_inv, 500);
        pulse_int();
        chk("starve4_fault", fault, 1);
        chk("starve4_d", d_inv, 0);
        ok_cnt = 0;
        send_frame(16'hA064, 16);
        chk("recover_ok", ok_cnt, 1);
        pulse_int();
        chk("recover_d", d_inv, 100);
        chk("recover_fault", fault, 0);

        // Reset mid-frame
        w_f = 16'hA1F4;
        ok_cnt = 0;
        err_cnt = 0;
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 8; i++) send_bit(w_f[15-i]);
        rst_n = 1'b0;
        wait_clk(2);
        chk("mrst_d_inv", d_inv, 0);
        chk("mrst_fault", fault, 0);
        chk("mrst_rx_ok", rx_ok, 0);
        chk("mrst_rx_err", rx_err, 0);
        rst_n = 1'b1;
        wait_clk(2);
        for (int i = 8; i < 16; i++) send_bit(w_f[15-i]);
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(20);
        chk("mrst_no_ok", ok_cnt, 0);
        chk("mrst_no_err", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
